bsg_manycore_reset_sequencer: RTL and testbench

- Multi-channel reset release controller for manycore testbenches; one channel per pod row or per loader/DUT domain.
- Waits until every enabled channel reports tag programming done, synchronises each done flag, then releases the channel resets one at a time with a programmable stagger.
- Provides a global cycle counter that starts at release, a timeout error for tag programming that never finishes, and re-sequencing if a done flag drops.

---
 rtl/bsg_manycore_reset_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_bsg_manycore_reset_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_reset_sequencer.sv
`timescale 1ns/1ps
// bsg_manycore_reset_sequencer
//
// Multi-channel reset release controller. The controller waits until every
// enabled channel reports that tag programming is done. Each done flag is
// synchronised first. The channel resets are then released one at a time,
// with a programmable stagger between releases. After sequencing finishes,
// a cycle counter runs in RUN. A done flag that drops in RUN returns the
// controller to WAIT_TAG and re-sequences. If tag programming never
// finishes, a sticky timeout error is raised.
//
// Ports:
//   clk_i          core clock
//   reset_i        asynchronous active-high reset
//   tag_done_i     per-channel tag-programming-done (asynchronous)
//   channel_en_i   per-channel participate flag, captured when leaving WAIT_TAG
//   reset_o        per-channel reset, active-high
//   all_released_o sequencing complete, system running
//   timeout_o      sticky tag-done timeout error
//   cycle_ctr_o    cycles spent in RUN
//
// Optional build macro: BSG_RESET_SEQ_TRACE_EN
//   When defined, simulation-only $display tracing is compiled in. It reports
//   FSM transitions and channel releases.

module bsg_manycore_reset_sequencer #(
  parameter int num_channels_p   = 4,
  parameter int sync_depth_p     = 3,
  parameter int stagger_cycles_p = 2,
  parameter int timeout_cycles_p = 65536,
  parameter int ctr_width_p      = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [num_channels_p-1:0] tag_done_i,
  input  logic [num_channels_p-1:0] channel_en_i,
  output logic [num_channels_p-1:0] reset_o,
  output logic                      all_released_o,
  output logic                      timeout_o,
  output logic [ctr_width_p-1:0]    cycle_ctr_o
);

  localparam int to_w_lp  = (timeout_cycles_p > 2) ? $clog2(timeout_cycles_p) : 1;
  localparam int ptr_w_lp = (num_channels_p > 1) ? $clog2(num_channels_p + 1) : 1;
  localparam int stg_w_lp = (stagger_cycles_p > 1) ? $clog2(stagger_cycles_p) : 1;

  localparam logic [to_w_lp-1:0]  to_last_lp  = to_w_lp'(timeout_cycles_p - 1);
  localparam logic [ptr_w_lp-1:0] ptr_end_lp  = ptr_w_lp'(num_channels_p);
  localparam logic [stg_w_lp-1:0] stg_load_lp = stg_w_lp'(stagger_cycles_p - 1);

  typedef enum logic [1:0] {
    WAIT_TAG,
    RELEASE,
    RUN,
    ERROR
  } state_e;

  state_e                    state_r, state_n;
  logic [num_channels_p-1:0] sync_r [sync_depth_p];
  logic [num_channels_p-1:0] done_s;
  logic                      all_done;
  logic                      drop;
  logic                      cur_en;
  logic [to_w_lp-1:0]        to_cnt_r, to_cnt_n;
  logic [ptr_w_lp-1:0]       ptr_r, ptr_n;
  logic [stg_w_lp-1:0]       stg_r, stg_n;
  logic [num_channels_p-1:0] en_mask_r, en_mask_n;
  logic [num_channels_p-1:0] reset_r, reset_n;
  logic [ctr_width_p-1:0]    ctr_r, ctr_n;

  // Each channel has its own synchroniser chain.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned k = 0; k < sync_depth_p; k++) begin
        sync_r[k] <= '0;
      end
    end else begin
      sync_r[0] <= tag_done_i;
      for (int unsigned k = 1; k < sync_depth_p; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  assign done_s   = sync_r[sync_depth_p-1];
  assign all_done = &(done_s | ~channel_en_i);
  assign drop     = |(en_mask_r & ~done_s);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r   <= WAIT_TAG;
      to_cnt_r  <= '0;
      ptr_r     <= '0;
      stg_r     <= '0;
      en_mask_r <= '0;
      reset_r   <= '1;
      ctr_r     <= '0;
    end else begin
      state_r   <= state_n;
      to_cnt_r  <= to_cnt_n;
      ptr_r     <= ptr_n;
      stg_r     <= stg_n;
      en_mask_r <= en_mask_n;
      reset_r   <= reset_n;
      ctr_r     <= ctr_n;
    end
  end

  always_comb begin
    state_n   = state_r;
    to_cnt_n  = to_cnt_r;
    ptr_n     = ptr_r;
    stg_n     = stg_r;
    en_mask_n = en_mask_r;
    reset_n   = reset_r;
    ctr_n     = '0;
    cur_en    = 1'b0;

    for (int unsigned i = 0; i < num_channels_p; i++) begin
      if (ptr_r == ptr_w_lp'(i)) begin
        cur_en = en_mask_r[i];
      end
    end

    case (state_r)
      WAIT_TAG: begin
        reset_n = '1;
        // all_done has priority over a timeout in the same cycle.
        if (all_done) begin
          state_n   = RELEASE;
          en_mask_n = channel_en_i;
          ptr_n     = '0;
          stg_n     = '0;
        end else if (to_cnt_r == to_last_lp) begin
          state_n = ERROR;
        end else begin
          to_cnt_n = to_cnt_r + to_w_lp'(1);
        end
      end

      RELEASE: begin
        to_cnt_n = '0;
        if (ptr_r == ptr_end_lp) begin
          // RUN is entered on the cycle in which the stagger count reaches zero.
          if (stg_r > stg_w_lp'(1)) begin
            stg_n = stg_r - stg_w_lp'(1);
          end else begin
            stg_n   = '0;
            state_n = RUN;
          end
        end else if (stg_r != '0) begin
          stg_n = stg_r - stg_w_lp'(1);
        end else if (cur_en) begin
          for (int unsigned i = 0; i < num_channels_p; i++) begin
            if (ptr_r == ptr_w_lp'(i)) begin
              reset_n[i] = 1'b0;
            end
          end
          stg_n = stg_load_lp;
          ptr_n = ptr_r + ptr_w_lp'(1);
        end else begin
          ptr_n = ptr_r + ptr_w_lp'(1);
        end
      end

      RUN: begin
        to_cnt_n = '0;
        if (drop) begin
          state_n = WAIT_TAG;
          reset_n = '1;
        end else begin
          ctr_n = ctr_r + ctr_width_p'(1);
        end
      end

      ERROR: begin
        reset_n = '1;
      end

      default: begin
        state_n = WAIT_TAG;
        reset_n = '1;
      end
    endcase
  end

  assign reset_o        = reset_r;
  assign all_released_o = (state_r == RUN);
  assign timeout_o      = (state_r == ERROR);
  assign cycle_ctr_o    = ctr_r;

`ifdef BSG_RESET_SEQ_TRACE_EN
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (state_n != state_r) begin
        $display("[%0t] reset_seq: %s -> %s (timeout_cnt=%0d cycle_ctr=%0d)",
                 $time, state_r.name(), state_n.name(), to_cnt_r, ctr_r);
        if (state_n == ERROR) begin
          $display("[%0t] reset_seq: timeout done_s=%b channel_en=%b missing=%b",
                   $time, done_s, channel_en_i, channel_en_i & ~done_s);
        end
      end
      for (int unsigned i = 0; i < num_channels_p; i++) begin
        if (reset_r[i] && !reset_n[i]) begin
          $display("[%0t] reset_seq: release channel %0d (timeout_cnt=%0d)",
                   $time, i, to_cnt_r);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_bsg_manycore_reset_sequencer.sv
`timescale 1ns/1ps
// Directed testbench for bsg_manycore_reset_sequencer.
// u_dut uses the default parameters. u_to uses a short timeout of 16 cycles.
// Both instances share the clock and the reset. Expected values are
// hand-computed edge numbers, counted from the first posedge after the
// reset is deasserted.

module tb_bsg_manycore_reset_sequencer;

  logic        clk;
  logic        reset_i;
  logic [3:0]  tag_done;
  logic [3:0]  chan_en;
  logic [3:0]  rst;
  logic        all_rel;
  logic        tmo;
  logic [31:0] ctr;

  logic [3:0]  tag_done_to;
  logic [3:0]  chan_en_to;
  logic [3:0]  rst_to;
  logic        all_rel_to;
  logic        tmo_to;
  logic [31:0] ctr_to;

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;

  bsg_manycore_reset_sequencer #(
    .num_channels_p  (4),
    .sync_depth_p    (3),
    .stagger_cycles_p(2),
    .timeout_cycles_p(65536),
    .ctr_width_p     (32)
  ) u_dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .tag_done_i    (tag_done),
    .channel_en_i  (chan_en),
    .reset_o       (rst),
    .all_released_o(all_rel),
    .timeout_o     (tmo),
    .cycle_ctr_o   (ctr)
  );

  bsg_manycore_reset_sequencer #(
    .num_channels_p  (4),
    .sync_depth_p    (3),
    .stagger_cycles_p(2),
    .timeout_cycles_p(16),
    .ctr_width_p     (32)
  ) u_to (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .tag_done_i    (tag_done_to),
    .channel_en_i  (chan_en_to),
    .reset_o       (rst_to),
    .all_released_o(all_rel_to),
    .timeout_o     (tmo_to),
    .cycle_ctr_o   (ctr_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d, t=%0t)", tag, got, exp, edge_n, $time);
    end
  endtask

  // Advance to 1ns after posedge number t.
  task automatic goto_edge(input int t);
    repeat (t - edge_n) @(posedge clk);
    edge_n = t;
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i     = 1'b1;
    tag_done    = 4'h0;
    chan_en     = 4'hF;
    tag_done_to = 4'h0;
    chan_en_to  = 4'hF;
    #12;
    check("rst_reset_o",      32'(rst),     'hF);
    check("rst_all_released", 32'(all_rel), 0);
    check("rst_timeout",      32'(tmo),     0);
    check("rst_cycle_ctr",    ctr,          0);
    check("rst_to_reset_o",   32'(rst_to),  'hF);

    // Basic release: tag_done rises before edge 10.
    @(negedge clk);
    reset_i = 1'b0;
    edge_n  = 0;
    goto_edge(9);
    tag_done = 4'hF;
    goto_edge(13); check("basic_e13_hold",  32'(rst), 'hF);
    goto_edge(14); check("basic_e14_ch0",   32'(rst), 'hE);
    goto_edge(15); check("basic_e15_stag",  32'(rst), 'hE);
    goto_edge(16); check("basic_e16_ch1",   32'(rst), 'hC);
    goto_edge(18); check("basic_e18_ch2",   32'(rst), 'h8);
    goto_edge(20); check("basic_e20_ch3",   32'(rst), 'h0);
                   check("basic_e20_notrun", 32'(all_rel), 0);
    goto_edge(21); check("basic_e21_run",   32'(all_rel), 1);
                   check("basic_e21_ctr",   ctr, 0);
    goto_edge(26); check("basic_e26_ctr",   ctr, 5);

    // Drop tag_done[1] in RUN, before edge 27.
    tag_done = 4'b1101;
    goto_edge(29); check("drop_e29_still",  32'(rst), 'h0);
                   check("drop_e29_ctr",    ctr, 8);
    goto_edge(30); check("drop_e30_reset",  32'(rst), 'hF);
                   check("drop_e30_ctr",    ctr, 0);
                   check("drop_e30_notrun", 32'(all_rel), 0);

    // Reassert before edge 31. The sequence repeats.
    tag_done = 4'hF;
    goto_edge(34); check("reseq_e34_hold",  32'(rst), 'hF);
    goto_edge(35); check("reseq_e35_ch0",   32'(rst), 'hE);
    goto_edge(36); check("reseq_e36_stag",  32'(rst), 'hE);

    // Asynchronous reset between clock edges during RELEASE.
    #2;
    reset_i = 1'b1;
    #1;
    check("async_reset_o",  32'(rst),     'hF);
    check("async_all_rel",  32'(all_rel), 0);
    check("async_ctr",      ctr,          0);

    // Channel 2 disabled. tag_done is already high, so the first edge is T.
    chan_en = 4'b1011;
    @(negedge clk);
    reset_i = 1'b0;
    edge_n  = 0;
    goto_edge(4);  check("dis_e4_hold",   32'(rst), 'hF);
    goto_edge(5);  check("dis_e5_ch0",    32'(rst), 'hE);
    goto_edge(7);  check("dis_e7_ch1",    32'(rst), 'hC);
    goto_edge(9);  check("dis_e9_skip",   32'(rst), 'hC);
    goto_edge(10); check("dis_e10_ch3",   32'(rst), 'h4);
                   check("dis_e10_notrun", 32'(all_rel), 0);
    goto_edge(11); check("dis_e11_run",   32'(all_rel), 1);
    chan_en = 4'hF;   // ignored until the next WAIT_TAG
    goto_edge(15); check("dis_e15_ch2_held", 32'(rst), 'h4);
                   check("dis_e15_run",      32'(all_rel), 1);

    // No channels enabled. RELEASE is entered at edge 1, RUN follows 5 edges later.
    chan_en  = 4'h0;
    tag_done = 4'h0;
    pulse_reset();
    goto_edge(5);  check("none_e5_notrun", 32'(all_rel), 0);
    goto_edge(6);  check("none_e6_run",    32'(all_rel), 1);
                   check("none_e6_reset",  32'(rst), 'hF);
    goto_edge(8);  check("none_e8_ctr",    ctr, 2);

    // Timeout on the short-timeout instance.
    tag_done_to = 4'b0111;
    pulse_reset();
    goto_edge(1);  check("to_cleared",     32'(tmo_to), 0);
    goto_edge(15); check("to_e15_none",    32'(tmo_to), 0);
    goto_edge(16); check("to_e16_err",     32'(tmo_to), 1);
                   check("to_e16_reset",   32'(rst_to), 'hF);
    tag_done_to = 4'hF;
    goto_edge(30); check("to_sticky",      32'(tmo_to), 1);
                   check("to_sticky_rst",  32'(rst_to), 'hF);
                   check("to_sticky_run",  32'(all_rel_to), 0);

    // all_done arrives on the same edge as the timeout, and all_done wins.
    tag_done_to = 4'h0;
    pulse_reset();
    goto_edge(12);
    tag_done_to = 4'hF;
    goto_edge(16); check("tie_e16_no_err", 32'(tmo_to), 0);
    goto_edge(17); check("tie_e17_ch0",    32'(rst_to), 'hE);
                   check("tie_e17_no_err", 32'(tmo_to), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
